// File: rtl/packet_gen.sv
// packet_gen: per-port ingress traffic generator.
//
// Takes one command word per packet through a small FIFO. For each command it
// frames a packet and streams it as 32-bit words under a valid/ready
// handshake. The frame is HDR0..HDR5 followed by the payload, and a packet of
// N blocks is N*8 words long (a blocks field of 0 counts as 1 block).
//
// Optional feature: when PACKET_GEN_SEQ_EN is defined, each payload word is a
// sequence tag {pkt_cnt[15:0], word_index[15:0]}. Without it, every payload
// word is 32'hFFFF_FFFF.
//
// Ports:
//   clk               clock
//   reset             asynchronous reset, active low
//   cmd_in            command: [29:28] dest port, [27:22] length in 32-byte
//                     blocks; all other bits are ignored
//   cmd_in_en         push strobe for cmd_in
//   cmd_full          command FIFO holds CMD_DEPTH entries
//   cmd_overflow      one-cycle pulse after a push is dropped
//   ingress_out       packet word to the crossbar
//   ingress_out_valid ingress_out holds a word
//   ingress_out_ready crossbar accepts the word (transfer = valid & ready)
//   busy              a packet is in flight
//   pkt_cnt           packets fully transmitted since reset, wraps
module packet_gen #(
  parameter logic [1:0]  PORT       = 2'd0,
  parameter int unsigned META_WIDTH = 32,
  parameter int unsigned CMD_DEPTH  = 8,
  parameter logic [45:0] MAC_PREFIX = 46'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [META_WIDTH-1:0] cmd_in,
  input  logic                  cmd_in_en,
  output logic                  cmd_full,
  output logic                  cmd_overflow,
  output logic [31:0]           ingress_out,
  output logic                  ingress_out_valid,
  input  logic                  ingress_out_ready,
  output logic                  busy,
  output logic [31:0]           pkt_cnt
);

  localparam int unsigned           AW        = $clog2(CMD_DEPTH);
  localparam logic [AW:0]           DEPTH_C   = (AW+1)'(CMD_DEPTH);
  localparam logic [META_WIDTH-1:0] USED_MASK = META_WIDTH'(32'h3FC0_0000);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_HDR2,
    S_HDR3,
    S_HDR4,
    S_HDR5,
    S_PAYLOAD
  } state_e;

  // The command FIFO stores only the fields that are used: {dest, blocks}.
  logic [7:0]    fifo_mem [CMD_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          overflow_q;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;

  state_e        state_q;
  logic [31:0]   out_q;
  logic          valid_q;
  logic [1:0]    dest_q;
  logic [8:0]    rem_q;
  logic [31:0]   pkt_cnt_q;
  logic [31:0]   ts_q;
  logic          xfer;

`ifdef PACKET_GEN_SEQ_EN
  logic [15:0]   seq_q;
`endif

  logic [7:0]    head;
  logic [1:0]    head_dest;
  logic [5:0]    head_blk_eff;
  logic [15:0]   head_len_bytes;
  logic          unused_cmd_bits;

  assign unused_cmd_bits = ^(cmd_in & ~USED_MASK);

  assign cmd_full      = (count_q == DEPTH_C);
  assign fifo_nonempty = (count_q != '0);
  assign push          = cmd_in_en && !cmd_full;
  assign pop           = (state_q == S_IDLE) && fifo_nonempty;

  assign head           = fifo_mem[rd_ptr_q];
  assign head_dest      = head[7:6];
  assign head_blk_eff   = (head[5:0] == 6'd0) ? 6'd1 : head[5:0];
  assign head_len_bytes = {5'd0, head_blk_eff, 5'd0};

  assign xfer = valid_q && ingress_out_ready;

  assign ingress_out       = out_q;
  assign ingress_out_valid = valid_q;
  assign cmd_overflow      = overflow_q;
  assign busy              = (state_q != S_IDLE);
  assign pkt_cnt           = pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_in[29:28], cmd_in[27:22]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      // A push into a full FIFO is dropped even if the FSM pops in the same cycle.
      overflow_q <= cmd_in_en && cmd_full;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ts_q <= '0;
    else        ts_q <= ts_q + 32'd1;
  end

  // Each output word is registered one transfer ahead: a transfer in state
  // HDRn loads the word for the next state. The HDR2 word loads ts_q + 1, so
  // it equals the timestamp of the cycle in which HDR2 first becomes valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      out_q     <= '0;
      valid_q   <= 1'b0;
      dest_q    <= '0;
      rem_q     <= '0;
      pkt_cnt_q <= '0;
`ifdef PACKET_GEN_SEQ_EN
      seq_q     <= '0;
`endif
    end else begin
      if (xfer) rem_q <= rem_q - 9'd1;
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          out_q   <= '0;
          if (fifo_nonempty) begin
            dest_q  <= head_dest;
            rem_q   <= {head_blk_eff, 3'b000};
            out_q   <= {head_len_bytes, MAC_PREFIX[45:30]};
            valid_q <= 1'b1;
            state_q <= S_HDR0;
          end
        end
        S_HDR0: if (xfer) begin
          out_q   <= {MAC_PREFIX[29:0], dest_q};
          state_q <= S_HDR1;
        end
        S_HDR1: if (xfer) begin
          out_q   <= ts_q + 32'd1;
          state_q <= S_HDR2;
        end
        S_HDR2: if (xfer) begin
          out_q   <= '0;
          state_q <= S_HDR3;
        end
        S_HDR3: if (xfer) begin
          out_q   <= {30'd0, PORT};
          state_q <= S_HDR4;
        end
        S_HDR4: if (xfer) begin
          out_q   <= {MAC_PREFIX[29:0], PORT};
          state_q <= S_HDR5;
        end
        S_HDR5: if (xfer) begin
`ifdef PACKET_GEN_SEQ_EN
          out_q <= {pkt_cnt_q[15:0], 16'd0};
          seq_q <= 16'd1;
`else
          out_q <= '1;
`endif
          state_q <= S_PAYLOAD;
        end
        S_PAYLOAD: if (xfer) begin
          if (rem_q == 9'd1) begin
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            out_q     <= '0;
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
          end else begin
`ifdef PACKET_GEN_SEQ_EN
            out_q <= {pkt_cnt_q[15:0], seq_q};
            seq_q <= seq_q + 16'd1;
`else
            out_q <= '1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_gen.sv
module tb_packet_gen;

  localparam logic [1:0]  TB_PORT   = 2'd1;
  localparam logic [45:0] TB_PREFIX = 46'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cmd_in;
  logic        cmd_in_en;
  logic        cmd_full;
  logic        cmd_overflow;
  logic [31:0] ingress_out;
  logic        ingress_out_valid;
  logic        ingress_out_ready;
  logic        busy;
  logic [31:0] pkt_cnt;

  packet_gen #(
    .PORT      (TB_PORT),
    .META_WIDTH(32),
    .CMD_DEPTH (8),
    .MAC_PREFIX(TB_PREFIX)
  ) dut (
    .clk              (clk),
    .reset            (rst_n),
    .cmd_in           (cmd_in),
    .cmd_in_en        (cmd_in_en),
    .cmd_full         (cmd_full),
    .cmd_overflow     (cmd_overflow),
    .ingress_out      (ingress_out),
    .ingress_out_valid(ingress_out_valid),
    .ingress_out_ready(ingress_out_ready),
    .busy             (busy),
    .pkt_cnt          (pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned tb_pkts = 0;
  logic [31:0] tb_ts;

  logic [31:0] wq[$];
  logic [31:0] tq[$];

  typedef struct {
    logic [1:0]  dest;
    logic [5:0]  blocks;
    int unsigned words;
    logic [31:0] hdr0;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Free-running cycle count since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end

  // Monitor: records every transferred word together with the timestamp of
  // the cycle in which that word first became valid. A stalled word must not
  // change.
  logic        prev_valid = 1'b0;
  logic        prev_xfer  = 1'b0;
  logic [31:0] prev_word  = '0;
  logic [31:0] first_ts   = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_xfer  = 1'b0;
    end else begin
      if (ingress_out_valid) begin
        if (prev_valid && !prev_xfer) chk("stall_hold", ingress_out, prev_word);
        else first_ts = tb_ts;
        if (ingress_out_ready) begin
          wq.push_back(ingress_out);
          tq.push_back(first_ts);
        end
      end
      prev_valid = ingress_out_valid;
      prev_xfer  = ingress_out_valid && ingress_out_ready;
      prev_word  = ingress_out;
    end
  end

  function automatic logic [31:0] model_word(input logic [1:0] dest, input logic [5:0] blk_raw,
                                             input int unsigned idx, input logic [31:0] ts,
                                             input int unsigned pktn);
    int unsigned blocks;
    logic [47:0] dmac;
    logic [47:0] smac;
    blocks = (blk_raw == 6'd0) ? 1 : int'(blk_raw);
    dmac   = {TB_PREFIX, dest};
    smac   = {TB_PREFIX, TB_PORT};
    case (idx)
      0: return {16'(blocks * 32), dmac[47:32]};
      1: return dmac[31:0];
      2: return ts;
      3: return 32'h0;
      4: return {30'h0, TB_PORT};
      5: return smac[31:0];
`ifdef PACKET_GEN_SEQ_EN
      default: return {16'(pktn), 16'(idx - 6)};
`else
      default: return (pktn == 32'hFFFF_FFFF) ? 32'h0 : 32'hFFFF_FFFF;
`endif
    endcase
  endfunction

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [1:0] dest, input logic [5:0] blk);
    logic [31:0] c;
    c        = $urandom;
    c[29:28] = dest;
    c[27:22] = blk;
    cmd_in    = c;
    cmd_in_en = 1'b1;
    @(posedge clk);
    #1;
    cmd_in_en = 1'b0;
  endtask

  task automatic wait_q(input int unsigned n);
    int unsigned cyc = 0;
    while (wq.size() < n && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (wq.size() < n) chk("wait_words", 32'(wq.size()), 32'(n));
  endtask

  task automatic check_packet(input logic [1:0] dest, input logic [5:0] blk,
                              output logic [31:0] hdr0, output int unsigned got);
    int unsigned n;
    int unsigned cyc = 0;
    logic [31:0] w;
    logic [31:0] ts;
    n = ((blk == 6'd0) ? 1 : int'(blk)) * 8;
    while (wq.size() < n && cyc < n * 10 + 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (wq.size() < n) chk("pkt_timeout", 32'(wq.size()), 32'(n));
    hdr0 = '0;
    got  = 0;
    for (int unsigned i = 0; i < n && wq.size() > 0; i++) begin
      w  = wq.pop_front();
      ts = tq.pop_front();
      if (i == 0) hdr0 = w;
      chk($sformatf("pkt%0d_word%0d", tb_pkts, i), w, model_word(dest, blk, i, ts, tb_pkts));
      got++;
    end
    tb_pkts++;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_valid"}, 32'(ingress_out_valid), 32'd0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 32'(tb_pkts));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] h;
    logic [31:0] held;
    int unsigned gw;
    int unsigned n;
    int unsigned cyc;
    logic [1:0]  d;
    logic [5:0]  b;

    tbl[0] = '{dest: 2'd2, blocks: 6'd1,  words: 8,   hdr0: 32'h0020_0000};
    tbl[1] = '{dest: 2'd3, blocks: 6'd63, words: 504, hdr0: 32'h07E0_0000};
    tbl[2] = '{dest: 2'd0, blocks: 6'd0,  words: 8,   hdr0: 32'h0020_0000};
    tbl[3] = '{dest: 2'd1, blocks: 6'd5,  words: 40,  hdr0: 32'h00A0_0000};
    tbl[4] = '{dest: 2'd2, blocks: 6'd32, words: 256, hdr0: 32'h0400_0000};

    rst_n             = 1'b0;
    cmd_in            = '0;
    cmd_in_en         = 1'b0;
    ingress_out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out", ingress_out, 32'h0);
    chk("rst_valid", 32'(ingress_out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(cmd_full), 32'd0);
    chk("rst_ovf", 32'(cmd_overflow), 32'd0);
    chk("rst_pkt_cnt", pkt_cnt, 32'h0);
    #3 rst_n = 1'b1;

    // First-word latency: push during cycle t, HDR0 valid in cycle t+2.
    sync();
    push_cmd(2'd2, 6'd1);
    @(negedge clk);
    chk("lat_t1_valid", 32'(ingress_out_valid), 32'd0);
    @(negedge clk);
    chk("lat_t2_valid", 32'(ingress_out_valid), 32'd1);
    chk("lat_t2_busy", 32'(busy), 32'd1);
    check_packet(2'd2, 6'd1, h, gw);
    chk("lat_hdr0", h, 32'h0020_0000);
    check_idle("lat_end");

    // Table of single packets with full-rate ready.
    for (int unsigned i = 0; i < 5; i++) begin
      sync();
      push_cmd(tbl[i].dest, tbl[i].blocks);
      check_packet(tbl[i].dest, tbl[i].blocks, h, gw);
      chk($sformatf("tbl%0d_hdr0", i), h, tbl[i].hdr0);
      chk($sformatf("tbl%0d_words", i), 32'(gw), 32'(tbl[i].words));
      check_idle($sformatf("tbl%0d_end", i));
    end

    // Backpressure during HDR2 and during the payload.
    sync();
    push_cmd(2'd1, 6'd2);
    wait_q(2);
    ingress_out_ready = 1'b0;
    @(negedge clk);
    held = ingress_out;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_hdr2_held", ingress_out, held);
    chk("bp_hdr2_valid", 32'(ingress_out_valid), 32'd1);
    sync();
    ingress_out_ready = 1'b1;
    wait_q(8);
    ingress_out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    ingress_out_ready = 1'b1;
    check_packet(2'd1, 6'd2, h, gw);
    chk("bp_words", 32'(gw), 32'd16);
    check_idle("bp_end");
    repeat (5) @(negedge clk);
    chk("bp_no_extra", 32'(wq.size()), 32'd0);

    // Two queued packets: one-cycle bubble between them; blocks=0 means 1.
    sync();
    push_cmd(2'd0, 6'd0);
    push_cmd(2'd3, 6'd1);
    check_packet(2'd0, 6'd0, h, gw);
    chk("gap_len0_hdr0", h, 32'h0020_0000);
    @(negedge clk);
    chk("gap_bubble", 32'(ingress_out_valid), 32'd0);
    @(negedge clk);
    chk("gap_next_valid", 32'(ingress_out_valid), 32'd1);
    check_packet(2'd3, 6'd1, h, gw);
    check_idle("gap_end");

    // Overflow: nine back-to-back pushes while a packet is being generated.
    sync();
    push_cmd(2'd3, 6'd4);
    sync();
    for (int unsigned i = 0; i < 9; i++) begin
      cmd_in        = $urandom;
      cmd_in[29:28] = 2'(i);
      cmd_in[27:22] = 6'd1;
      cmd_in_en     = 1'b1;
      @(negedge clk);
      chk($sformatf("ovf_full_before_push%0d", i), 32'(cmd_full), (i == 8) ? 32'd1 : 32'd0);
      chk($sformatf("ovf_pulse_before_push%0d", i), 32'(cmd_overflow), 32'd0);
      @(posedge clk);
      #1;
    end
    cmd_in_en = 1'b0;
    @(negedge clk);
    chk("ovf_pulse", 32'(cmd_overflow), 32'd1);
    chk("ovf_full_hold", 32'(cmd_full), 32'd1);
    @(negedge clk);
    chk("ovf_pulse_end", 32'(cmd_overflow), 32'd0);
    check_packet(2'd3, 6'd4, h, gw);
    for (int unsigned i = 0; i < 8; i++) check_packet(2'(i), 6'd1, h, gw);
    repeat (20) @(negedge clk);
    chk("ovf_no_ninth_packet", 32'(wq.size()), 32'd0);
    chk("ovf_pkt_cnt", pkt_cnt, 32'(tb_pkts));

    // Randomized commands with random backpressure.
    for (int unsigned r = 0; r < 12; r++) begin
      d = 2'($urandom_range(0, 3));
      b = 6'($urandom_range(0, 6));
      sync();
      push_cmd(d, b);
      n   = ((b == 6'd0) ? 1 : int'(b)) * 8;
      cyc = 0;
      while (wq.size() < n && cyc < 2000) begin
        ingress_out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        cyc++;
      end
      ingress_out_ready = 1'b1;
      check_packet(d, b, h, gw);
      chk($sformatf("rnd%0d_words", r), 32'(gw), 32'(n));
    end
    repeat (3) @(negedge clk);
    chk("rnd_pkt_cnt", pkt_cnt, 32'(tb_pkts));

    // Reset in the middle of a payload, with a second command queued.
    sync();
    push_cmd(2'd3, 6'd4);
    wait_q(10);
    push_cmd(2'd0, 6'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(ingress_out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 32'h0);
    chk("mid_rst_full", 32'(cmd_full), 32'd0);
    chk("mid_rst_out", ingress_out, 32'h0);
    wq.delete();
    tq.delete();
    tb_pkts = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_fifo_empty", 32'(wq.size()), 32'd0);
    chk("post_rst_idle", 32'(ingress_out_valid), 32'd0);
    sync();
    push_cmd(2'd2, 6'd1);
    check_packet(2'd2, 6'd1, h, gw);
    chk("post_rst_hdr0", h, 32'h0020_0000);
    check_idle("post_rst_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
